// File: rtl/lsu_misalign_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_pkg : funct3/state encodings and size/legality helpers for the LSU
// Revision: 1.0
// ----------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LD  = 3'b011,
      LBU = 3'b100,
      LHU = 3'b101,
      LWU = 3'b110
   } funct3_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2,
      RESP  = 2'd3
   } state_e;

   function automatic logic [3:0] size_bytes(input logic [2:0] fun3);
      logic [3:0] sz;
      case (fun3[1:0])
         2'b00:   sz = 4'd1;
         2'b01:   sz = 4'd2;
         2'b10:   sz = 4'd4;
         default: sz = 4'd8;
      endcase
      return sz;
   endfunction

   function automatic logic is_legal(input logic [2:0] fun3, input logic we,
                                     input int data_width);
      logic ok;
      ok = 1'b1;
      if (fun3 == 3'b111) ok = 1'b0;
      if ((data_width == 32) && ((fun3 == 3'b011) || (fun3 == 3'b110))) ok = 1'b0;
      if (we && ((fun3 == 3'b011) || fun3[2])) ok = 1'b0;
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_misalign_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_misalign_unit_if : core request/response and memory beat bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface lsu_misalign_unit_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [2:0]             req_fun3;
   logic [AddrWidth-1:0]   req_addr;
   logic [DataWidth-1:0]   req_wdata;
   logic                   resp_valid;
   logic [DataWidth-1:0]   resp_rdata;
   logic                   resp_err;
   logic                   mem_req;
   logic                   mem_we;
   logic [AddrWidth-1:0]   mem_addr;
   logic [DataWidth/8-1:0] mem_wmask;
   logic [DataWidth-1:0]   mem_wdata;
   logic                   mem_valid;
   logic [DataWidth-1:0]   mem_rdata;

   modport master (
      output req_valid, req_we, req_fun3, req_addr, req_wdata, mem_valid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_fun3, req_addr, req_wdata, mem_valid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/lsu_misalign_unit_load_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_load_align : shift, truncate and sign/zero-extend a two-word load buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_load_align
   import lsu_pkg::*;
#(
   parameter int DataWidth = 32,
   localparam int NB = DataWidth / 8,
   localparam int OB = $clog2(NB)
) (
   input  logic [2*DataWidth-1:0] buf_i,
   input  logic [OB-1:0]          off_i,
   input  logic [2:0]             fun3_i,
   output logic [DataWidth-1:0]   rdata_o
);
   logic [2*DataWidth-1:0] w_shifted;
   logic [3:0]             w_size;
   logic                   w_sign;
   logic                   w_ext;

   always_comb begin
      w_shifted = buf_i >> {off_i, 3'b000};
      w_size    = size_bytes(fun3_i);
      case (fun3_i[1:0])
         2'b00:   w_sign = w_shifted[7];
         2'b01:   w_sign = w_shifted[15];
         2'b10:   w_sign = w_shifted[31];
         default: w_sign = w_shifted[63];
      endcase
      w_ext   = w_sign & ~fun3_i[2];
      rdata_o = '0;
      for (int b = 0; b < NB; b++) begin
         rdata_o[8*b +: 8] = (b < int'(w_size)) ? w_shifted[8*b +: 8] : {8{w_ext}};
      end
   end
endmodule
`default_nettype wire

// File: rtl/lsu_misalign_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_misalign_unit : load/store alignment with two-beat split for straddling accesses
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_misalign_unit
   import lsu_pkg::*;
#(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32
) (
   input  logic               clk,
   input  logic               rst,
   lsu_misalign_unit_if.slave bus
);
   localparam int NB = DataWidth / 8;
   localparam int OB = $clog2(NB);

   state_e                 state_q, state_d;
   logic                   we_q;
   logic [2:0]             fun3_q;
   logic [AddrWidth-1:0]   addr_q;
   logic [DataWidth-1:0]   wdata_q;
   logic                   split_q;
   logic                   err_q;
   logic [2*DataWidth-1:0] buf_q;

   logic                   w_handshake;
   logic                   w_req_legal;
   logic                   w_req_split;
   logic [OB-1:0]          w_off;
   logic [3:0]             w_size;
   logic [AddrWidth-1:0]   w_base;
   logic [2*NB-1:0]        w_lane_mask;
   logic [2*DataWidth-1:0] w_byte_mask;
   logic [2*DataWidth-1:0] w_lane_data;
   logic [DataWidth-1:0]   w_load_data;

   assign w_handshake = bus.req_valid && (state_q == IDLE);
   assign w_req_legal = is_legal(bus.req_fun3, bus.req_we, DataWidth);
   assign w_req_split = (int'(bus.req_addr[OB-1:0]) + int'(size_bytes(bus.req_fun3))) > NB;
   assign w_off       = addr_q[OB-1:0];
   assign w_size      = size_bytes(fun3_q);
   assign w_base      = {addr_q[AddrWidth-1:OB], {OB{1'b0}}};

   // Store data is masked to the access size so unwritten lanes carry zero.
   always_comb begin
      w_lane_mask = (2*NB)'((32'd1 << w_size) - 32'd1) << w_off;
      w_byte_mask = '0;
      for (int b = 0; b < 2*NB; b++) begin
         w_byte_mask[8*b +: 8] = {8{w_lane_mask[b]}};
      end
      w_lane_data = ({{DataWidth{1'b0}}, wdata_q} << {w_off, 3'b000}) & w_byte_mask;
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_wmask  = '0;
      bus.mem_wdata  = '0;
      bus.resp_valid = 1'b0;
      bus.resp_err   = 1'b0;
      bus.resp_rdata = '0;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_d = w_req_legal ? BEAT0 : RESP;
         end
         BEAT0: begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = we_q;
            bus.mem_addr = w_base;
            if (we_q) begin
               bus.mem_wmask = w_lane_mask[NB-1:0];
               bus.mem_wdata = w_lane_data[DataWidth-1:0];
            end
            if (bus.mem_valid) state_d = split_q ? BEAT1 : RESP;
         end
         BEAT1: begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = we_q;
            bus.mem_addr = w_base + AddrWidth'(NB);
            if (we_q) begin
               bus.mem_wmask = w_lane_mask[2*NB-1:NB];
               bus.mem_wdata = w_lane_data[2*DataWidth-1:DataWidth];
            end
            if (bus.mem_valid) state_d = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_err   = err_q;
            bus.resp_rdata = (we_q || err_q) ? '0 : w_load_data;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         fun3_q  <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         split_q <= 1'b0;
         err_q   <= 1'b0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (w_handshake) begin
            we_q    <= bus.req_we;
            fun3_q  <= bus.req_fun3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            split_q <= w_req_split;
            err_q   <= ~w_req_legal;
         end
         if ((state_q == BEAT0) && bus.mem_valid) buf_q[DataWidth-1:0] <= bus.mem_rdata;
         if ((state_q == BEAT1) && bus.mem_valid) buf_q[2*DataWidth-1:DataWidth] <= bus.mem_rdata;
      end
   end

   lsu_load_align #(
      .DataWidth (DataWidth)
   ) u_load_align (
      .buf_i   (buf_q),
      .off_i   (w_off),
      .fun3_i  (fun3_q),
      .rdata_o (w_load_data)
   );
endmodule
`default_nettype wire

// File: tb/tb_lsu_misalign_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lsu_misalign_unit : directed vector table plus back-to-back and reset-abort sequences
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_lsu_misalign_unit;
   logic clk;
   logic rst;

   lsu_misalign_unit_if #(.DataWidth(32), .AddrWidth(32)) bus ();

   lsu_misalign_unit #(
      .DataWidth (32),
      .AddrWidth (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        we;
      logic [2:0]  fun3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] m0;
      logic [31:0] m1;
      int          wt;
      int          nb;
      logic [31:0] a0;
      logic [3:0]  k0;
      logic [31:0] d0;
      logic [31:0] a1;
      logic [3:0]  k1;
      logic [31:0] d1;
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] mem [logic [31:0]];
   int          wait_cycles = 0;
   int          wcnt = 0;
   int          nbeats = 0;
   logic [31:0] beat_addr  [4];
   logic [3:0]  beat_mask  [4];
   logic [31:0] beat_wdata [4];
   logic        beat_we    [4];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Memory responder: asserts mem_valid after wait_cycles idle mem_req cycles.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (wcnt >= wait_cycles) begin
            bus.mem_valid = 1'b1;
            bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
            if (nbeats < 4) begin
               beat_addr[nbeats]  = bus.mem_addr;
               beat_mask[nbeats]  = bus.mem_wmask;
               beat_wdata[nbeats] = bus.mem_wdata;
               beat_we[nbeats]    = bus.mem_we;
            end
            nbeats++;
            wcnt = 0;
         end else begin
            bus.mem_valid = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_valid = 1'b0;
         wcnt = 0;
      end
   end

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] base;
      int          lat;
      bit          got;
      base = v.addr & 32'hFFFF_FFFC;
      mem[base]         = v.m0;
      mem[base + 32'd4] = v.m1;
      wait_cycles = v.wt;
      nbeats = 0;
      @(negedge clk);
      chk({tag, ".ready"}, bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_we    = v.we;
      bus.req_fun3  = v.fun3;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0;
      got = 0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (bus.resp_valid) got = 1;
      end
      chk({tag, ".lat"}, got ? lat : -1, v.lat);
      chk({tag, ".rdata"}, bus.resp_rdata, v.rdata);
      chk({tag, ".err"}, bus.resp_err, v.err);
      @(negedge clk);
      chk({tag, ".pulse"}, bus.resp_valid, 0);
      chk({tag, ".nbeats"}, nbeats, v.nb);
      if (v.nb >= 1 && nbeats >= 1) begin
         chk({tag, ".a0"}, beat_addr[0], v.a0);
         chk({tag, ".we0"}, beat_we[0], v.we);
         if (v.we) begin
            chk({tag, ".k0"}, beat_mask[0], v.k0);
            chk({tag, ".d0"}, beat_wdata[0], v.d0);
         end
      end
      if (v.nb >= 2 && nbeats >= 2) begin
         chk({tag, ".a1"}, beat_addr[1], v.a1);
         if (v.we) begin
            chk({tag, ".k1"}, beat_mask[1], v.k1);
            chk({tag, ".d1"}, beat_wdata[1], v.d1);
         end
      end
   endtask

   vec_t vecs [18];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t lw_after;
      bit   found;
      int   seen;

      //          we    fun3    addr           wdata          m0             m1             wt nb a0             k0     d0             a1             k1     d1             rdata          err   lat
      vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         32'h0,         0, 1, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0, 2};
      vecs[1]  = '{1'b1, 3'b010, 32'h0000_0102, 32'h1122_3344, 32'h0,         32'h0,         0, 2, 32'h0000_0100, 4'hC, 32'h3344_0000, 32'h0000_0104, 4'h3, 32'h0000_1122, 32'h0,         1'b0, 3};
      vecs[2]  = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,         32'h3400_0000, 32'h0000_00F2, 0, 2, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_0104, 4'h0, 32'h0,         32'hFFFF_F234, 1'b0, 3};
      vecs[3]  = '{1'b0, 3'b101, 32'h0000_0103, 32'h0,         32'h3400_0000, 32'h0000_00F2, 0, 2, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_0104, 4'h0, 32'h0,         32'h0000_F234, 1'b0, 3};
      vecs[4]  = '{1'b0, 3'b000, 32'h0000_0205, 32'h0,         32'h0000_8000, 32'h0,         0, 1, 32'h0000_0204, 4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'hFFFF_FF80, 1'b0, 2};
      vecs[5]  = '{1'b0, 3'b100, 32'h0000_0205, 32'h0,         32'h0000_8000, 32'h0,         0, 1, 32'h0000_0204, 4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0000_0080, 1'b0, 2};
      vecs[6]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h1234_5678, 32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1};
      vecs[7]  = '{1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0,         32'hBEEF_0000, 32'h0000_CAFE, 0, 2, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'h0000_0000, 4'h0, 32'h0,         32'hCAFE_BEEF, 1'b0, 3};
      vecs[8]  = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h8000_0001, 32'h0,         0, 1, 32'h0000_0300, 4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h8000_0001, 1'b0, 2};
      vecs[9]  = '{1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 32'h0,         32'h0,         0, 1, 32'h0000_0100, 4'h8, 32'hAB00_0000, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0, 2};
      vecs[10] = '{1'b1, 3'b001, 32'h0000_0106, 32'hFFFF_7788, 32'h0,         32'h0,         0, 1, 32'h0000_0104, 4'hC, 32'h7788_0000, 32'h0,         4'h0, 32'h0,         32'h0,         1'b0, 2};
      vecs[11] = '{1'b1, 3'b100, 32'h0000_0100, 32'h5555_5555, 32'h0,         32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1};
      vecs[12] = '{1'b0, 3'b111, 32'h0000_0100, 32'h0,         32'h7777_7777, 32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1};
      vecs[13] = '{1'b0, 3'b110, 32'h0000_0100, 32'h0,         32'h7777_7777, 32'h0,         0, 0, 32'h0,         4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h0,         1'b1, 1};
      vecs[14] = '{1'b0, 3'b001, 32'h0000_01FF, 32'h0,         32'h8500_0000, 32'h0000_00C3, 0, 2, 32'h0000_01FC, 4'h0, 32'h0,         32'h0000_0200, 4'h0, 32'h0,         32'hFFFF_C385, 1'b0, 3};
      vecs[15] = '{1'b1, 3'b010, 32'h0000_0101, 32'hA1B2_C3D4, 32'h0,         32'h0,         0, 2, 32'h0000_0100, 4'hE, 32'hB2C3_D400, 32'h0000_0104, 4'h1, 32'h0000_00A1, 32'h0,         1'b0, 3};
      vecs[16] = '{1'b0, 3'b001, 32'h0000_0103, 32'h0,         32'h3400_0000, 32'h0000_00F2, 2, 2, 32'h0000_0100, 4'h0, 32'h0,         32'h0000_0104, 4'h0, 32'h0,         32'hFFFF_F234, 1'b0, 7};
      vecs[17] = '{1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'h8000_0001, 32'h0,         1, 1, 32'h0000_0300, 4'h0, 32'h0,         32'h0,         4'h0, 32'h0,         32'h8000_0001, 1'b0, 3};

      clk = 1'b0;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_fun3  = 3'b000;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.mem_valid = 1'b0;
      bus.mem_rdata = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset.req_ready",  bus.req_ready, 1);
      chk("reset.mem_req",    bus.mem_req, 0);
      chk("reset.mem_we",     bus.mem_we, 0);
      chk("reset.mem_addr",   bus.mem_addr, 0);
      chk("reset.mem_wmask",  bus.mem_wmask, 0);
      chk("reset.mem_wdata",  bus.mem_wdata, 0);
      chk("reset.resp_valid", bus.resp_valid, 0);
      chk("reset.resp_rdata", bus.resp_rdata, 0);
      chk("reset.resp_err",   bus.resp_err, 0);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Request held high across a transaction is taken only once IDLE returns.
      mem[32'h0000_0204] = 32'h0000_8000;
      wait_cycles = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_fun3  = 3'b000;
      bus.req_addr  = 32'h0000_0205;
      @(negedge clk);
      chk("b2b.ready_c1", bus.req_ready, 0);
      chk("b2b.memreq_c1", bus.mem_req, 1);
      @(negedge clk);
      chk("b2b.resp_c2", bus.resp_valid, 1);
      chk("b2b.rdata_c2", bus.resp_rdata, 32'hFFFF_FF80);
      chk("b2b.ready_c2", bus.req_ready, 0);
      bus.req_fun3 = 3'b100;
      @(negedge clk);
      chk("b2b.ready_c3", bus.req_ready, 1);
      chk("b2b.resp_c3", bus.resp_valid, 0);
      @(negedge clk);
      chk("b2b.ready_c4", bus.req_ready, 0);
      chk("b2b.memreq_c4", bus.mem_req, 1);
      @(negedge clk);
      chk("b2b.resp_c5", bus.resp_valid, 1);
      chk("b2b.rdata_c5", bus.resp_rdata, 32'h0000_0080);
      bus.req_valid = 1'b0;
      @(negedge clk);

      // Reset during BEAT1 of a split store, coinciding with mem_valid.
      wait_cycles = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_fun3  = 3'b010;
      bus.req_addr  = 32'h0000_0102;
      bus.req_wdata = 32'h1122_3344;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(negedge clk);
         if (bus.mem_req && bus.mem_addr == 32'h0000_0104) found = 1;
      end
      chk("rst.beat1_seen", found, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst.mem_req", bus.mem_req, 0);
      chk("rst.req_ready", bus.req_ready, 1);
      chk("rst.resp_valid", bus.resp_valid, 0);
      rst = 1'b0;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.resp_valid) seen++;
      end
      chk("rst.no_resp", seen, 0);
      lw_after = vecs[8];
      run_vec(lw_after, "rst.lw_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lsu_misalign_unit.md
# lsu_misalign_unit

Parametrised load/store alignment unit between the core's memory stage and the single-port data memory. Accepts one load or store request per transaction and performs byte-lane steering, write masking and load sign/zero extension for 32- or 64-bit datapaths. Unlike the combinational store/load wrapper, it supports misaligned accesses that straddle a word boundary by issuing two memory beats and merging the results. Illegal size encodings are flagged as errors.

## Interface
- DataWidth, 32, datapath width; legal values are 32 or 64. NB = DataWidth/8 and OB = log2(NB).
- AddrWidth, 32, byte address width.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request.
- req_ready  out  1  unit idle; handshake occurs when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_fun3  in  3  RISC-V funct3 (b/h/w/d/bu/hu/wu).
- req_addr  in  AddrWidth  byte address; any alignment.
- req_wdata  in  DataWidth  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DataWidth  extended load data; 0 for stores and errors.
- resp_err  out  1  illegal funct3; qualified by resp_valid.
- mem_req  out  1  memory beat request; held until mem_valid.
- mem_we  out  1  beat is a write.
- mem_addr  out  AddrWidth  word-aligned beat address (low OB bits are 0).
- mem_wmask  out  NB  byte-lane write enables.
- mem_wdata  out  DataWidth  lane-steered write data.
- mem_valid  in  1  beat done; ignored while mem_req = 0.
- mem_rdata  in  DataWidth  read word; sampled when mem_valid.

## Operation
- **Size decoding**
  - 000/100 → 1 byte; 001/101 → 2 bytes; 010/110 → 4 bytes; 011 → 8 bytes.
  - 100/101/110 zero-extend; the others sign-extend.
  - Illegal: 111 always; 011 and 110 when DataWidth = 32; 011, 100, 101 and 110 when req_we = 1.
- **Request capture.** On handshake, latch we, fun3, addr and wdata. Compute off = addr[OB-1:0] and split = (off + size > NB).
- **States.** IDLE → BEAT0 → (BEAT1 if split) → RESP → IDLE. An illegal request goes IDLE → RESP with resp_err = 1.
- **BEAT0**
  - mem_addr = addr with the low OB bits cleared.
  - Store lanes: form a 2·NB lane mask ((1<<size)-1) << off and 2·DataWidth data wdata << (8·off). BEAT0 drives the low halves.
  - Load: on mem_valid, capture mem_rdata into the low half of a 2·DataWidth buffer.
- **BEAT1**
  - mem_addr = BEAT0 address + NB, wrapping modulo 2^AddrWidth.
  - Stores drive the high halves of the lane mask and data.
  - Loads capture mem_rdata into the high half of the buffer.
- **RESP**
  - Loads: resp_rdata = (buffer >> 8·off), truncated to size, then extended per funct3.
  - Stores: resp_rdata = 0.
  - resp_valid = 1 for exactly one cycle. There is no response backpressure.
- **Reset outputs.** state = IDLE, req_ready = 1; mem_req, mem_we, mem_wmask, mem_wdata, mem_addr, resp_* = 0.
- **Boundary conditions**
  - req_valid outside IDLE is not accepted.
  - rst asserted in any state aborts the transaction: no resp_valid, and the next cycle is IDLE with mem_req = 0.
  - mem_valid in the same cycle as rst is discarded.
  - Unmasked write lanes drive 0.

## Timing
- Handshake at edge c0; mem_req is asserted from cycle c0+1, registered.
- mem_valid is sampled combinationally at edge k. Then:
  - Unsplit access: resp_valid in cycle k+1.
  - Split access: BEAT1 mem_req is asserted in cycle k+1.
- Minimum latency with zero-wait memory (mem_valid in the first mem_req cycle):
  - Aligned: 2 cycles from handshake to resp_valid.
  - Split: 3 cycles.
  - Error: 1 cycle.
- req_ready is high only in IDLE, including the RESP→IDLE cycle. This allows back-to-back requests every 3 cycles for aligned zero-wait accesses.
- mem_addr, mem_we, mem_wmask and mem_wdata are stable while mem_req = 1.

## Structure
- Shared package lsu_pkg contains:
  - funct3 enum: LB, LH, LW, LD, LBU, LHU, LWU.
  - State enum: IDLE, BEAT0, BEAT1, RESP.
  - Function size_bytes(fun3).
  - Function is_legal(fun3, we, DataWidth).
- Sub-module lsu_load_align: combinational shift, truncate and extend from the 2·DataWidth buffer, off and fun3 to resp_rdata. It is reused by the future cache-side path.

## Test plan
- DataWidth = 32, sw 0x100 data 0xDEADBEEF → one beat: mem_addr 0x100, wmask 1111, wdata 0xDEADBEEF; resp_valid 2 cycles after handshake, err 0.
- sw 0x102 data 0x11223344 → beat0: addr 0x100, wmask 1100, wdata 0x33440000; beat1: addr 0x104, wmask 0011, wdata 0x00001122.
- lh 0x103, word@0x100 = 0x34000000, word@0x104 = 0x000000F2 → beats at 0x100 then 0x104; resp_rdata 0xFFFFF234. The same access with lhu returns 0x0000F234.
- lb 0x205, word@0x204 = 0x00008000 → 0xFFFFFF80; lbu → 0x00000080. A second req_valid held high during the transaction is accepted only in the cycle after resp_valid.
- DataWidth = 32, ld (fun3 011) → no mem_req; resp_valid at c0+1 with resp_err = 1. lw at 0xFFFFFFFE → beat1 mem_addr 0x00000000.
- rst pulsed during BEAT1 of a split store → mem_req = 0 the next cycle, req_ready = 1, no resp_valid. A subsequent aligned lw completes normally.
